// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit.
// Holds FSM states, opcodes and functs, datapath select codes and the instruction-class record.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD    = 3'd0,
      ALU_SUB    = 3'd1,
      ALU_AND    = 3'd2,
      ALU_OR     = 3'd3,
      ALU_SLT    = 3'd4,
      ALU_LUI    = 3'd5,
      ALU_PASS_A = 3'd6
   } alu_op_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [1:0] PC_SRC_PC4 = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;
   localparam logic [1:0] PC_SRC_RS  = 2'b11;

   localparam logic [1:0] ALUB_RT   = 2'b00;
   localparam logic [1:0] ALUB_FOUR = 2'b01;
   localparam logic [1:0] ALUB_SEXT = 2'b10;
   localparam logic [1:0] ALUB_ZEXT = 2'b11;

   localparam logic [1:0] RDST_RT = 2'b00;
   localparam logic [1:0] RDST_RD = 2'b01;
   localparam logic [1:0] RDST_RA = 2'b10;

   typedef struct packed {
      logic r_type;
      logic jr;
      logic addi;
      logic ori;
      logic lui;
      logic mem_ld;
      logic mem_st;
      logic branch;
      logic jump;
      logic link;
      logic illegal;
   } instr_class_t;

   function automatic alu_op_e funct_alu_op(input logic [5:0] f);
      case (f)
         FN_SUB:  return ALU_SUB;
         FN_AND:  return ALU_AND;
         FN_OR:   return ALU_OR;
         FN_SLT:  return ALU_SLT;
         default: return ALU_ADD;
      endcase
   endfunction

endpackage

// File: rtl/mc_control_fsm_decode.sv
// Combinational opcode/funct to instruction-class decode.
module mc_instr_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0]   opcode_i,
   input  logic [5:0]   funct_i,
   output instr_class_t cls_o
);

   always_comb begin
      cls_o = '0;
      case (opcode_i)
         OP_RTYPE: begin
            case (funct_i)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: cls_o.r_type = 1'b1;
               FN_JR:                                 cls_o.jr     = 1'b1;
               default:                               cls_o.illegal = 1'b1;
            endcase
         end
         OP_J:    cls_o.jump   = 1'b1;
         OP_JAL:  cls_o.link   = 1'b1;
         OP_BEQ:  cls_o.branch = 1'b1;
         OP_ADDI: cls_o.addi   = 1'b1;
         OP_ORI:  cls_o.ori    = 1'b1;
         OP_LUI:  cls_o.lui    = 1'b1;
         OP_LW:   cls_o.mem_ld = 1'b1;
         OP_SW:   cls_o.mem_st = 1'b1;
         default: cls_o.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-subset main control: FETCH/DECODE/EXEC/MEM/WB sequencer
// driving datapath selects and strobes, plus a retired-instruction counter.
module mc_control_fsm
   import mc_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             ir_write,
   output logic             mem_write,
   output logic             reg_write,
   output logic [1:0]       reg_dst,
   output logic             mem_to_reg,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic             illegal_op,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_count
);

   state_e             state_q, state_d;
   logic [5:0]         op_q, op_d;
   logic [5:0]         funct_q, funct_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   instr_class_t       cls;

   // DECODE looks at the live IR fields; later states use the copy taken at the end of DECODE.
   assign op_d    = (state_q == S_DECODE) ? opcode : op_q;
   assign funct_d = (state_q == S_DECODE) ? funct  : funct_q;

   mc_instr_decode u_dec (
      .opcode_i (op_d),
      .funct_i  (funct_d),
      .cls_o    (cls)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q    <= '0;
         funct_q <= '0;
         cnt_q   <= '0;
      end else begin
         op_q    <= op_d;
         funct_q <= funct_d;
         cnt_q   <= cnt_d;
      end
   end

   assign cnt_d       = cnt_q + CNT_W'(instr_done);
   assign instr_count = cnt_q;

   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = (cls.illegal || cls.jump) ? S_FETCH : S_EXEC;
         S_EXEC: begin
            if (cls.mem_ld || cls.mem_st)  state_d = S_MEM;
            else if (cls.branch || cls.jr) state_d = S_FETCH;
            else                           state_d = S_WB;
         end
         S_MEM:    state_d = cls.mem_ld ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
         default:  state_d = S_FETCH;
      endcase
   end

   always_comb begin
      pc_write   = 1'b0;
      pc_src     = PC_SRC_PC4;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = RDST_RT;
      mem_to_reg = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = ALUB_RT;
      alu_op     = ALU_ADD;
      illegal_op = 1'b0;
      instr_done = 1'b0;

      // Write-back selects stay put across the remaining states so the clocked muxes see a stable value.
      if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) mem_to_reg = cls.mem_ld;
      if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
         if (cls.r_type)    reg_dst = RDST_RD;
         else if (cls.link) reg_dst = RDST_RA;
      end

      case (state_q)
         S_FETCH: begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = ALUB_FOUR;
         end
         S_DECODE: begin
            if (cls.illegal) begin
               illegal_op = 1'b1;
            end else if (cls.jump) begin
               pc_write   = 1'b1;
               pc_src     = PC_SRC_JMP;
               instr_done = 1'b1;
            end
         end
         S_EXEC: begin
            if (cls.r_type) begin
               alu_src_a = 1'b1;
               alu_op    = funct_alu_op(funct_q);
            end else if (cls.addi || cls.mem_ld || cls.mem_st) begin
               alu_src_a = 1'b1;
               alu_src_b = ALUB_SEXT;
            end else if (cls.ori || cls.lui) begin
               alu_src_a = 1'b1;
               alu_src_b = ALUB_ZEXT;
               alu_op    = cls.ori ? ALU_OR : ALU_LUI;
            end else if (cls.branch) begin
               alu_src_a  = 1'b1;
               alu_op     = ALU_SUB;
               pc_write   = zero;
               pc_src     = PC_SRC_BR;
               instr_done = 1'b1;
            end else if (cls.jr) begin
               alu_src_a  = 1'b1;
               pc_write   = 1'b1;
               pc_src     = PC_SRC_RS;
               instr_done = 1'b1;
            end else if (cls.link) begin
               alu_op = ALU_PASS_A;
            end
         end
         S_MEM: begin
            if (cls.mem_st) begin
               mem_write  = 1'b1;
               instr_done = 1'b1;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            if (cls.link) begin
               pc_write = 1'b1;
               pc_src   = PC_SRC_JMP;
            end
         end
         default: ;
      endcase

      // Strobes are held off for the whole of reset, even though the state already reads FETCH.
      if (!rst_n) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         illegal_op = 1'b0;
         instr_done = 1'b0;
      end
   end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle MIPS-subset main control unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the datapath select and strobe lines, including reg_dst into the destination-register mux and mem_to_reg into the clocked write-back data mux.
- Sits directly upstream of those muxes. Also keeps a retired-instruction counter for bring-up.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag, sampled in EXEC
- pc_write  out  1  PC load strobe
- pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs
- ir_write  out  1  IR load strobe
- mem_write  out  1  data-memory write strobe
- reg_write  out  1  register-file write strobe
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_to_reg  out  1  0 ALU-out, 1 memory data
- alu_src_a  out  1  0 PC, 1 rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 zero-ext imm
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LUI, 6 PASS_A
- illegal_op  out  1  one-cycle pulse on an unsupported opcode or funct
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- State register: 3 bits, FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.
- Async reset sets: state to FETCH, latched op/funct to 0, instr_count to 0.
- While rst_n=0, every output strobe (pc_write, ir_write, mem_write, reg_write, illegal_op, instr_done) is forced to 0 combinationally.
- The first active edge after reset release executes FETCH.
- Reset mid-instruction aborts the instruction: no partial write, and no count increment.
- Outputs are Moore-style, decoded from state plus the op/funct latched at the end of DECODE.
- FETCH: ir_write=1, pc_write=1, pc_src=00, alu_src_a=0, alu_src_b=01, alu_op=ADD. Next state DECODE.
- DECODE: latch opcode and funct.
  - j (0x02): pc_write=1, pc_src=10, instr_done=1. Next state FETCH.
  - Illegal op/funct: illegal_op=1, no strobes, no count. Next state FETCH.
  - All other supported ops: next state EXEC.
- EXEC, by instruction:
  - R-type (add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A): alu_src_a=1, alu_src_b=00. Next state WB.
  - addi 0x08: sign-ext, ADD. Next state WB.
  - ori 0x0D: zero-ext, OR. Next state WB.
  - lui 0x0F: zero-ext, LUI. Next state WB.
  - lw 0x23 / sw 0x2B: sign-ext, ADD. Next state MEM.
  - beq 0x04: SUB; pc_write=zero, pc_src=01, instr_done=1. Next state FETCH.
  - jr (R-type, funct 0x08): pc_write=1, pc_src=11, instr_done=1. Next state FETCH.
  - jal 0x03: alu_src_a=0, PASS_A (link = PC+4). Next state WB.
- MEM:
  - sw: mem_write=1, instr_done=1. Next state FETCH.
  - lw: next state WB.
- WB: reg_write=1, instr_done=1. Next state FETCH.
  - reg_dst: 01 for R-type, 10 for jal, 00 otherwise.
  - jal also asserts pc_write=1 with pc_src=10.
- mem_to_reg: equals 1 for lw, 0 otherwise. Held constant from DECODE through WB so the clocked data mux samples a stable select one edge before the register-file write.
- reg_dst: held constant from EXEC through WB.
- Cycle counts: j 2; beq and jr 3; R-type, I-type ALU, sw, jal 4; lw 5.
- instr_count increments by 1 on each edge where instr_done=1 and wraps to 0 at all-ones.
- Undefined values (state 5–7 or any other encoding): recover to FETCH on the next edge with no strobes.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encodings
  - opcode and funct constants
  - alu_op, pc_src, alu_src_b and reg_dst encodings
- Natural sub-module: mc_instr_decode, a combinational op/funct-to-class decode (r_type, mem_ld, mem_st, branch, jump, link, illegal).
- The FSM and counter live in the top.

Test Plan:
- Reset asserted mid-EXEC of add → all strobes 0 immediately; after release, a FETCH pulse (ir_write=1) on the first edge; instr_count=0.
- add (op 0x00, funct 0x20) → 4 cycles; WB has reg_write=1, reg_dst=01, mem_to_reg=0; instr_count +1.
- lw (0x23) → 5 cycles; mem_to_reg=1 from DECODE through WB; reg_write only in cycle 5 with reg_dst=00.
- beq (0x04) with zero=1, then again with zero=0 → pc_write=1, pc_src=01 in EXEC for the first; pc_write=0 for the second; both done in 3 cycles.
- jal (0x03) → EXEC alu_op=PASS_A, alu_src_a=0; WB reg_write=1, reg_dst=10, pc_write=1, pc_src=10.
- Illegal opcode 0x3F → illegal_op pulse in DECODE, no writes, back to FETCH, instr_count unchanged; with CNT_W=4, 16 retired instructions wrap the count to 0.
